// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port synchronous memory between instruction fetch (IF) and load/store (D).
// Optional IF starvation guard is enabled with `define MEMARB_STARVE_GUARD_EN.
module mem_bus_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [DW/8-1:0] d_be,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int BW = DW / 8;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [CW-1:0] LAT_C = CW'(RD_LAT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  if (RD_LAT < 1 || RD_LAT > 4 || STARVE_MAX < 1) begin : g_bad_param
    $error("mem_bus_arbiter: RD_LAT must be 1..4 and STARVE_MAX >= 1");
  end

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          owner_q, owner_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          idle;
  logic          if_win;
  logic          d_win;
  logic          rd_done;

  // Gating with resetn keeps every combinational output low while reset is held.
  assign idle    = resetn && (state_q == ST_IDLE);
  assign rd_done = (state_q == ST_WAIT) && (cnt_q == LAT_C);

`ifdef MEMARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

  logic [SW-1:0] starve_q, starve_d;
  logic          starve_hit;

  assign starve_hit = (starve_q == STARVE_C);

  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (idle) begin
      if (if_req && (starve_hit || !d_req)) begin
        if_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!if_req || if_win) begin
      starve_d = '0;
    end else if (d_win && !starve_hit) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (idle) begin
      if (d_req) begin
        d_win = 1'b1;
      end else if (if_req) begin
        if_win = 1'b1;
      end
    end
  end
`endif

  assign if_gnt = if_win;
  assign d_gnt  = d_win;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_we ? d_be : {BW{1'b1}};
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_win) begin
      mem_en    = 1'b1;
      mem_be    = {BW{1'b1}};
      mem_addr  = if_addr;
    end
  end

  // Read data is forwarded straight from memory in the rvalid cycle and held afterwards.
  assign if_rvalid = rd_done && (owner_q == OWN_IF);
  assign d_rvalid  = rd_done && (owner_q == OWN_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_q;
  assign busy      = (state_q != ST_IDLE);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    owner_d    = owner_q;
    if_rdata_d = if_rvalid ? mem_rdata : if_rdata_q;
    d_rdata_d  = d_rvalid  ? mem_rdata : d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if ((d_win && !d_we) || if_win) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_ONE;
          owner_d = d_win ? OWN_D : OWN_IF;
        end
      end
      ST_WAIT: begin
        if (rd_done) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q != LAT_C) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      owner_q    <= OWN_IF;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      owner_q    <= owner_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed, table-driven bench for mem_bus_arbiter (default parameters, RD_LAT=2, STARVE_MAX=4).
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  int compared = 0;
  int mismatched = 0;

  mem_bus_arbiter #(.AW(32), .DW(32), .RD_LAT(2), .STARVE_MAX(4)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // ctl packs {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, busy}
  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic [6:0]  exp_ctl;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;
  } vec_t;

  vec_t vecs[14];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    d_req     = v.d_req;
    d_we      = v.d_we;
    d_be      = v.d_be;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic clearInputs();
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
    d_be = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
  endtask

  function automatic logic [6:0] ctl_now();
    return {if_gnt, d_gnt, mem_en, mem_we, if_rvalid, d_rvalid, busy};
  endfunction

  function automatic logic any_output();
    return |{if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy};
  endfunction

  initial begin
    //           if  if_addr  d  we be    d_addr  d_wdata       mem_rdata     ctl        be    addr   wdata         if_rdata      d_rdata
    vecs[0]  = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0,        32'h0,        7'b0000000, 4'h0, 32'h0,  32'h0,        32'h0,        32'h0};
    vecs[1]  = '{1, 32'h10, 0, 0, 4'h0, 32'h0,  32'h0,        32'h0,        7'b1010000, 4'hF, 32'h10, 32'h0,        32'h0,        32'h0};
    vecs[2]  = '{0, 32'h0,  1, 1, 4'h3, 32'h20, 32'hDEADBEEF, 32'h11111111, 7'b0000001, 4'h0, 32'h0,  32'h0,        32'h0,        32'h0};
    vecs[3]  = '{0, 32'h0,  1, 1, 4'h3, 32'h20, 32'hDEADBEEF, 32'hCAFEF00D, 7'b0000101, 4'h0, 32'h0,  32'h0,        32'hCAFEF00D, 32'h0};
    vecs[4]  = '{0, 32'h0,  1, 1, 4'h3, 32'h20, 32'hDEADBEEF, 32'h22222222, 7'b0111000, 4'h3, 32'h20, 32'hDEADBEEF, 32'hCAFEF00D, 32'h0};
    vecs[5]  = '{0, 32'h0,  1, 1, 4'hF, 32'h24, 32'h01234567, 32'h0,        7'b0111000, 4'hF, 32'h24, 32'h01234567, 32'hCAFEF00D, 32'h0};
    vecs[6]  = '{0, 32'h0,  1, 1, 4'h8, 32'h28, 32'h89ABCDEF, 32'h0,        7'b0111000, 4'h8, 32'h28, 32'h89ABCDEF, 32'hCAFEF00D, 32'h0};
    vecs[7]  = '{1, 32'h14, 1, 0, 4'h0, 32'h40, 32'h0,        32'h0,        7'b0110000, 4'hF, 32'h40, 32'h0,        32'hCAFEF00D, 32'h0};
    vecs[8]  = '{1, 32'h14, 0, 0, 4'h0, 32'h0,  32'h0,        32'h33333333, 7'b0000001, 4'h0, 32'h0,  32'h0,        32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1, 32'h14, 0, 0, 4'h0, 32'h0,  32'h0,        32'h55AA55AA, 7'b0000011, 4'h0, 32'h0,  32'h0,        32'hCAFEF00D, 32'h55AA55AA};
    vecs[10] = '{1, 32'h14, 0, 0, 4'h0, 32'h0,  32'h0,        32'h44444444, 7'b1010000, 4'hF, 32'h14, 32'h0,        32'hCAFEF00D, 32'h55AA55AA};
    vecs[11] = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0,        32'h0,        7'b0000001, 4'h0, 32'h0,  32'h0,        32'hCAFEF00D, 32'h55AA55AA};
    vecs[12] = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0,        32'h0BADC0DE, 7'b0000101, 4'h0, 32'h0,  32'h0,        32'h0BADC0DE, 32'h55AA55AA};
    vecs[13] = '{0, 32'h0,  0, 0, 4'h0, 32'h0,  32'h0,        32'h0,        7'b0000000, 4'h0, 32'h0,  32'h0,        32'h0BADC0DE, 32'h55AA55AA};

    // Reset state with requests idle
    resetn = 1'b0;
    clearInputs();
    #3;
    checkOutput("reset_outputs", 64'(any_output()), 64'h0);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Cycle-by-cycle table: IF read, writes blocked during WAIT, back-to-back writes, D-over-IF priority
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkOutput($sformatf("vec%0d_ctl", i),      64'(ctl_now()),  64'(vecs[i].exp_ctl));
      checkOutput($sformatf("vec%0d_be", i),       64'(mem_be),     64'(vecs[i].exp_be));
      checkOutput($sformatf("vec%0d_addr", i),     64'(mem_addr),   64'(vecs[i].exp_addr));
      checkOutput($sformatf("vec%0d_wdata", i),    64'(mem_wdata),  64'(vecs[i].exp_wdata));
      checkOutput($sformatf("vec%0d_if_rdata", i), 64'(if_rdata),   64'(vecs[i].exp_if_rdata));
      checkOutput($sformatf("vec%0d_d_rdata", i),  64'(d_rdata),    64'(vecs[i].exp_d_rdata));
    end

    // Starvation: continuous D reads with IF held; grants possible every RD_LAT+1 = 3 cycles
    for (int k = 0; k < 15; k++) begin
      logic exp_d;
      logic exp_if;
      @(negedge clk);
      clearInputs();
      if_req = 1'b1; if_addr = 32'h18;
      d_req  = 1'b1; d_addr  = 32'h80;
`ifdef MEMARB_STARVE_GUARD_EN
      exp_d  = (k % 3 == 0) && (k / 3 < 4);
      exp_if = (k == 12);
`else
      exp_d  = (k % 3 == 0);
      exp_if = 1'b0;
`endif
      #2;
      checkOutput($sformatf("starve%0d_d_gnt", k),  64'(d_gnt),  64'(exp_d));
      checkOutput($sformatf("starve%0d_if_gnt", k), 64'(if_gnt), 64'(exp_if));
    end
    @(negedge clk);
    clearInputs();
    #2;
    checkOutput("starve_end_busy", 64'(busy), 64'h0);

    // Reset cutting a D read at T+1, released at T+3
    @(negedge clk);
    clearInputs();
    d_req = 1'b1; d_addr = 32'h60;
    #2;
    checkOutput("rst_seq_d_gnt", 64'(d_gnt), 64'h1);
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h1C;
    mem_rdata = 32'h77777777;
    resetn = 1'b0;
    #1;
    checkOutput("rst_seq_outputs_t1", 64'(any_output()), 64'h0);
    @(negedge clk);
    #1;
    checkOutput("rst_seq_outputs_t2", 64'(any_output()), 64'h0);
    @(negedge clk);
    clearInputs();
    mem_rdata = 32'h77777777;
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      checkOutput($sformatf("rst_after%0d_ctl", k), 64'(ctl_now()), 64'h0);
      checkOutput($sformatf("rst_after%0d_d_rdata", k), 64'(d_rdata), 64'h0);
      @(negedge clk);
    end

    // IF read after reset still works end to end
    if_req = 1'b1; if_addr = 32'h30;
    #2;
    checkOutput("post_rst_if_gnt", 64'(ctl_now()), 64'(7'b1010000));
    @(negedge clk);
    clearInputs();
    @(negedge clk);
    mem_rdata = 32'hA5A5_0F0F;
    #2;
    checkOutput("post_rst_if_rvalid", 64'(ctl_now()), 64'(7'b0000101));
    checkOutput("post_rst_if_rdata", 64'(if_rdata), 64'hA5A5_0F0F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
